// File: rtl/pipeline_control_ldst_arbiter.sv
// Two-port ownership arbiter for the pipeline-control load/store port.
// Port 0 is the IRQ call sequencer, port 1 the exception/IDT sequencer.
module pipeline_control_ldst_arbiter #(
  parameter int P_ROUND_ROBIN = 1
) (
  input  logic        iCLOCK,
  input  logic        inRESET,
  input  logic        iRESET_SYNC,
  // port 0
  input  logic        iREQ0_LDST_USE,
  input  logic        iREQ0_LDST_REQ,
  output logic        oREQ0_LDST_BUSY,
  input  logic [1:0]  iREQ0_LDST_ORDER,
  input  logic        iREQ0_LDST_RW,
  input  logic [31:0] iREQ0_LDST_ADDR,
  input  logic [31:0] iREQ0_LDST_DATA,
  output logic        oREQ0_LDST_REQ,
  output logic [31:0] oREQ0_LDST_DATA,
  // port 1
  input  logic        iREQ1_LDST_USE,
  input  logic        iREQ1_LDST_REQ,
  output logic        oREQ1_LDST_BUSY,
  input  logic [1:0]  iREQ1_LDST_ORDER,
  input  logic        iREQ1_LDST_RW,
  input  logic [31:0] iREQ1_LDST_ADDR,
  input  logic [31:0] iREQ1_LDST_DATA,
  output logic        oREQ1_LDST_REQ,
  output logic [31:0] oREQ1_LDST_DATA,
  // downstream
  output logic        oLDST_USE,
  output logic        oLDST_REQ,
  output logic [1:0]  oLDST_ORDER,
  output logic        oLDST_RW,
  output logic [31:0] oLDST_ADDR,
  output logic [31:0] oLDST_DATA,
  input  logic        iLDST_BUSY,
  input  logic        iLDST_REQ,
  input  logic [31:0] iLDST_DATA,
  // status
  output logic [1:0]  oOWNER,
  output logic        oPROTOCOL_ERR
);

  // Encoding doubles as the oOWNER value.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_t;

  state_t      b_state;
  state_t      state_next;
  logic [1:0]  b_count;
  logic [1:0]  count_next;
  logic        b_rr_ptr;
  logic        rr_next;
  logic        b_err;
  logic        err_next;

  logic        own0;
  logic        own1;
  logic        owned;
  logic        full;
  logic        sel_use;
  logic        sel_req;
  logic        accept;
  logic        rsp_ok;
  logic        grant1;

  always_comb begin
    own0    = (b_state == OWN0);
    own1    = (b_state == OWN1);
    owned   = own0 | own1;
    full    = (b_count == 2'd3);
    sel_use = own1 ? iREQ1_LDST_USE : iREQ0_LDST_USE;
    sel_req = own1 ? iREQ1_LDST_REQ : iREQ0_LDST_REQ;

    // A draining owner (USE dropped) keeps receiving responses but issues nothing new.
    oLDST_USE   = owned;
    oLDST_REQ   = owned & sel_use & sel_req & ~full;
    oLDST_ORDER = own1 ? iREQ1_LDST_ORDER : (own0 ? iREQ0_LDST_ORDER : 2'b00);
    oLDST_RW    = own1 ? iREQ1_LDST_RW    : (own0 & iREQ0_LDST_RW);
    oLDST_ADDR  = own1 ? iREQ1_LDST_ADDR  : (own0 ? iREQ0_LDST_ADDR : 32'h0);
    oLDST_DATA  = own1 ? iREQ1_LDST_DATA  : (own0 ? iREQ0_LDST_DATA : 32'h0);

    oREQ0_LDST_BUSY = own0 ? (iLDST_BUSY | full) : 1'b1;
    oREQ1_LDST_BUSY = own1 ? (iLDST_BUSY | full) : 1'b1;

    accept = oLDST_REQ & ~iLDST_BUSY;
    rsp_ok = iLDST_REQ & owned & (b_count != 2'd0);

    // Responses with no owner or nothing outstanding are dropped, never routed.
    oREQ0_LDST_REQ  = rsp_ok & own0;
    oREQ1_LDST_REQ  = rsp_ok & own1;
    oREQ0_LDST_DATA = (rsp_ok & own0) ? iLDST_DATA : 32'h0;
    oREQ1_LDST_DATA = (rsp_ok & own1) ? iLDST_DATA : 32'h0;

    oOWNER        = b_state;
    oPROTOCOL_ERR = b_err;
  end

  always_comb begin
    count_next = b_count;
    case ({accept, rsp_ok})
      2'b10:   count_next = b_count + 2'd1;
      2'b01:   count_next = b_count - 2'd1;
      default: count_next = b_count;
    endcase

    err_next   = b_err | (iLDST_REQ & ~rsp_ok);
    grant1     = iREQ1_LDST_USE & (~iREQ0_LDST_USE | ((P_ROUND_ROBIN != 0) & b_rr_ptr));
    state_next = b_state;
    rr_next    = b_rr_ptr;

    case (b_state)
      IDLE: begin
        if (iREQ0_LDST_USE | iREQ1_LDST_USE) begin
          state_next = grant1 ? OWN1 : OWN0;
          rr_next    = ~grant1;
        end
      end
      OWN0: if (!iREQ0_LDST_USE && count_next == 2'd0) state_next = IDLE;
      OWN1: if (!iREQ1_LDST_USE && count_next == 2'd0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      b_state  <= IDLE;
      b_count  <= 2'd0;
      b_rr_ptr <= 1'b0;
      b_err    <= 1'b0;
    end else if (iRESET_SYNC) begin
      b_state  <= IDLE;
      b_count  <= 2'd0;
      b_rr_ptr <= 1'b0;
      b_err    <= 1'b0;
    end else begin
      b_state  <= state_next;
      b_count  <= count_next;
      b_rr_ptr <= rr_next;
      b_err    <= err_next;
    end
  end

endmodule

// File: tb/tb_pipeline_control_ldst_arbiter.sv
// Randomized scoreboard bench for pipeline_control_ldst_arbiter (round-robin and fixed-priority builds).
module tb_pipeline_control_ldst_arbiter;

  localparam int NCYC = 3000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        rst_sync = 1'b0;
  logic        u0 = 0, r0 = 0, w0 = 0, u1 = 0, r1 = 0, w1 = 0;
  logic [1:0]  o0 = 0, o1 = 0;
  logic [31:0] a0 = 0, d0 = 0, a1 = 0, d1 = 0;
  logic        ld_busy = 0, ld_rsp = 0;
  logic [31:0] ld_rdata = 0;
  logic        u0b = 0, u1b = 0;

  logic        busy0, busy1, rq0, rq1, f_use, f_req, f_rw, perr;
  logic [31:0] rd0, rd1, f_addr, f_data;
  logic [1:0]  f_order, owner;

  logic        busy0_b, busy1_b, rq0_b, rq1_b, f_use_b, f_req_b, f_rw_b, perr_b;
  logic [31:0] rd0_b, rd1_b, f_addr_b, f_data_b;
  logic [1:0]  f_order_b, owner_b;

  pipeline_control_ldst_arbiter #(.P_ROUND_ROBIN(1)) dut (
    .iCLOCK(clk), .inRESET(rst_n), .iRESET_SYNC(rst_sync),
    .iREQ0_LDST_USE(u0), .iREQ0_LDST_REQ(r0), .oREQ0_LDST_BUSY(busy0),
    .iREQ0_LDST_ORDER(o0), .iREQ0_LDST_RW(w0), .iREQ0_LDST_ADDR(a0), .iREQ0_LDST_DATA(d0),
    .oREQ0_LDST_REQ(rq0), .oREQ0_LDST_DATA(rd0),
    .iREQ1_LDST_USE(u1), .iREQ1_LDST_REQ(r1), .oREQ1_LDST_BUSY(busy1),
    .iREQ1_LDST_ORDER(o1), .iREQ1_LDST_RW(w1), .iREQ1_LDST_ADDR(a1), .iREQ1_LDST_DATA(d1),
    .oREQ1_LDST_REQ(rq1), .oREQ1_LDST_DATA(rd1),
    .oLDST_USE(f_use), .oLDST_REQ(f_req), .oLDST_ORDER(f_order), .oLDST_RW(f_rw),
    .oLDST_ADDR(f_addr), .oLDST_DATA(f_data),
    .iLDST_BUSY(ld_busy), .iLDST_REQ(ld_rsp), .iLDST_DATA(ld_rdata),
    .oOWNER(owner), .oPROTOCOL_ERR(perr)
  );

  pipeline_control_ldst_arbiter #(.P_ROUND_ROBIN(0)) dut_fixed (
    .iCLOCK(clk), .inRESET(rst_n), .iRESET_SYNC(rst_sync),
    .iREQ0_LDST_USE(u0b), .iREQ0_LDST_REQ(1'b0), .oREQ0_LDST_BUSY(busy0_b),
    .iREQ0_LDST_ORDER(2'b00), .iREQ0_LDST_RW(1'b0), .iREQ0_LDST_ADDR(32'h0), .iREQ0_LDST_DATA(32'h0),
    .oREQ0_LDST_REQ(rq0_b), .oREQ0_LDST_DATA(rd0_b),
    .iREQ1_LDST_USE(u1b), .iREQ1_LDST_REQ(1'b0), .oREQ1_LDST_BUSY(busy1_b),
    .iREQ1_LDST_ORDER(2'b00), .iREQ1_LDST_RW(1'b0), .iREQ1_LDST_ADDR(32'h0), .iREQ1_LDST_DATA(32'h0),
    .oREQ1_LDST_REQ(rq1_b), .oREQ1_LDST_DATA(rd1_b),
    .oLDST_USE(f_use_b), .oLDST_REQ(f_req_b), .oLDST_ORDER(f_order_b), .oLDST_RW(f_rw_b),
    .oLDST_ADDR(f_addr_b), .oLDST_DATA(f_data_b),
    .iLDST_BUSY(1'b0), .iLDST_REQ(1'b0), .iLDST_DATA(32'h0),
    .oOWNER(owner_b), .oPROTOCOL_ERR(perr_b)
  );

  typedef struct {
    logic [1:0]  owner;
    logic        busy0;
    logic        busy1;
    logic [68:0] fwd;
    logic        rsp0;
    logic        rsp1;
    logic [31:0] rd0;
    logic [31:0] rd1;
    logic        err;
    logic [1:0]  owner_b;
  } exp_t;

  typedef struct {
    int          port;
    logic [31:0] data;
  } rsp_t;

  exp_t exp_q[$];
  rsp_t rsp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  bit   done = 0;

  // Reference model: who owns the port, how many responses are owed, whose turn is next.
  int m_own = 0;   // 0 none, 1 port 0, 2 port 1
  int m_out = 0;
  int m_rr = 0;
  bit m_err = 0;
  int m2_own = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [1:0] own_code(input int o);
    return (o == 0) ? 2'b00 : ((o == 1) ? 2'b01 : 2'b10);
  endfunction

  task automatic model_reset();
    m_own = 0; m_out = 0; m_rr = 0; m_err = 0; m2_own = 0;
  endtask

  // Driver: randomize inputs, predict the cycle's outputs, then advance the model.
  initial begin
    exp_t e;
    int   div;
    bit   cu, cr, fwd_req, rsp_ok, accepted, want0, want1;
    int   p;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk);
      #1;
      rst_n    = !(cyc < 3 || cyc == 1500 || cyc == 1501);
      rst_sync = rst_n && ($urandom % 120 == 0);
      u0  = u0 ? ($urandom % 10 != 0) : ($urandom % 6 == 0);
      u1  = u1 ? ($urandom % 10 != 0) : ($urandom % 6 == 0);
      r0  = $urandom % 2; r1 = $urandom % 2;
      o0  = 2'($urandom); o1 = 2'($urandom);
      w0  = $urandom % 2; w1 = $urandom % 2;
      a0  = $urandom; a1 = $urandom; d0 = $urandom; d1 = $urandom;
      ld_busy  = ($urandom % 4 == 0);
      div      = (cyc < 1000) ? 4 : ((cyc < 2000) ? 2 : 7);
      ld_rsp   = rst_n && ((m_out > 0 && $urandom % div == 0) || ($urandom % 60 == 0));
      ld_rdata = $urandom;
      u0b = $urandom % 3 != 0;
      u1b = $urandom % 3 != 0;
      if (!rst_n) model_reset();

      p  = m_own - 1;
      cu = (p == 1) ? u1 : u0;
      cr = (p == 1) ? r1 : r0;
      fwd_req  = (m_own != 0) && cu && cr && (m_out < 3);
      accepted = fwd_req && !ld_busy;
      rsp_ok   = ld_rsp && (m_own != 0) && (m_out > 0);

      e.owner = own_code(m_own);
      e.busy0 = (m_own == 1) ? (ld_busy || m_out == 3) : 1'b1;
      e.busy1 = (m_own == 2) ? (ld_busy || m_out == 3) : 1'b1;
      if (m_own == 1) e.fwd = {1'b1, fwd_req, o0, w0, a0, d0};
      else if (m_own == 2) e.fwd = {1'b1, fwd_req, o1, w1, a1, d1};
      else e.fwd = '0;
      e.rsp0 = rsp_ok && m_own == 1;
      e.rsp1 = rsp_ok && m_own == 2;
      e.rd0  = e.rsp0 ? ld_rdata : 32'h0;
      e.rd1  = e.rsp1 ? ld_rdata : 32'h0;
      e.err  = m_err;
      e.owner_b = own_code(m2_own);
      exp_q.push_back(e);
      if (rsp_ok) rsp_q.push_back('{port: p, data: ld_rdata});

      if (rst_n && rst_sync) model_reset();
      else if (rst_n) begin
        if (ld_rsp && !rsp_ok) m_err = 1;
        m_out = m_out + (accepted ? 1 : 0) - (rsp_ok ? 1 : 0);
        if (m_own == 0) begin
          if (u0 || u1) begin
            want1 = u1 && (!u0 || m_rr == 1);
            m_own = want1 ? 2 : 1;
            m_rr  = want1 ? 0 : 1;
          end
        end else if (!cu && m_out == 0) m_own = 0;
        // Fixed-priority instance never has traffic, so ownership tracks USE alone.
        want0 = (m2_own == 1) ? u0b : 1'b0;
        want1 = (m2_own == 2) ? u1b : 1'b0;
        if (m2_own == 0) m2_own = u0b ? 1 : (u1b ? 2 : 0);
        else if (!want0 && !want1) m2_own = 0;
      end
    end
    @(posedge clk);
    #1;
    rst_n = 1; ld_rsp = 0; u0 = 0; u1 = 0;
    done = 1;
  end

  // Monitor: per-cycle status checks plus response scoreboard.
  initial begin
    exp_t e;
    rsp_t r;
    int   guard;
    guard = 0;
    while (!done && guard < NCYC + 100) begin
      @(negedge clk);
      guard++;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("owner", 128'(owner), 128'(e.owner));
        chk("busy", 128'({busy0, busy1}), 128'({e.busy0, e.busy1}));
        chk("fwd", 128'({f_use, f_req, f_order, f_rw, f_addr, f_data}), 128'(e.fwd));
        chk("rsp_route", 128'({rq0, rq1, rd0, rd1}), 128'({e.rsp0, e.rsp1, e.rd0, e.rd1}));
        chk("proto_err", 128'(perr), 128'(e.err));
        chk("owner_fixed", 128'(owner_b), 128'(e.owner_b));
        if (rq0 || rq1) begin
          if (rsp_q.size() == 0) chk("rsp_unexpected", 128'({rq0, rq1}), 128'(0));
          else begin
            r = rsp_q.pop_front();
            chk("rsp_port", 128'(rq1 ? 1 : 0), 128'(r.port));
            chk("rsp_data", 128'(rq1 ? rd1 : rd0), 128'(r.data));
          end
        end
      end
    end
    if (!done) chk("timeout", 128'(0), 128'(1));
    chk("rsp_drained", 128'(rsp_q.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
